// File: rtl/bus_src_fifo.sv
// Per-terminal source FIFO feeding the bus generator/arbiter: first-word
// fall-through head, one-cycle pop strobe, sticky overflow/underflow accounting.
module bus_src_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth   = 15,
  parameter int af_lvl  = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  output logic                       ovf,
  output logic                       udf,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_flags
);

  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);

  logic [pckg_sz-1:0] mem_q [depth];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;

  logic pop_eff, wr_acc, drop, udf_evt;

  // Pointers wrap at depth-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pndng       = (count_q != '0);
  assign full        = (count_q == CW'(depth));
  assign almost_full = (count_q >= CW'(af_lvl));
  assign count       = count_q;
  assign ovf         = ovf_q;
  assign udf         = udf_q;
  assign drop_cnt    = drop_cnt_q;
  assign D_pop       = pndng ? mem_q[rd_ptr_q] : '0;

  assign pop_eff = pop && pndng;
  assign wr_acc  = wr_en && (!full || pop_eff);
  assign drop    = wr_en && full && !pop_eff;
  assign udf_evt = pop && !pndng;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d   = wr_acc  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop_eff ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    drop_cnt_d = drop_cnt_q;

    case ({wr_acc, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new event in the same cycle as clr_flags overrides the clear.
    if (clr_flags) begin
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
    if (udf_evt) udf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates D_pop, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_bus_src_fifo.sv
// Self-checking bench for bus_src_fifo: vector table, directed corner cases and
// a randomized run, all compared against a queue-based reference model.
module tb_bus_src_fifo;

  localparam int DEPTH = 15;
  localparam int AF    = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          pop = 1'b0;
  logic          clr_flags = 1'b0;
  logic          full, almost_full, pndng, ovf, udf;
  logic [CW-1:0] count;
  logic [15:0]   D_pop;
  logic [7:0]    drop_cnt;

  bus_src_fifo #(.pckg_sz(16), .depth(DEPTH), .af_lvl(AF)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .count(count), .pndng(pndng),
    .D_pop(D_pop), .pop(pop), .ovf(ovf), .udf(udf), .drop_cnt(drop_cnt),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue plus flag state.
  logic [15:0] mq[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  int          m_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic compare_model(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"},       32'(count),       32'(n));
    check({tag, ".pndng"},       32'(pndng),       32'(n != 0));
    check({tag, ".full"},        32'(full),        32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
    check({tag, ".D_pop"},       32'(D_pop),       (n != 0) ? 32'(mq[0]) : 32'h0);
    check({tag, ".ovf"},         32'(ovf),         32'(m_ovf));
    check({tag, ".udf"},         32'(udf),         32'(m_udf));
    check({tag, ".drop_cnt"},    32'(drop_cnt),    32'(m_drop));
  endtask

  // Apply one cycle of stimulus, advance the model, then sample 1 ns after the edge.
  task automatic drive(input logic w, input logic [15:0] d, input logic p, input logic c,
                       input string tag);
    logic empty, is_full, pe, acc, drp;
    wr_en = w; wr_data = d; pop = p; clr_flags = c;
    empty   = (mq.size() == 0);
    is_full = (mq.size() == DEPTH);
    pe  = p && !empty;
    acc = w && (!is_full || pe);
    drp = w && is_full && !pe;
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; m_drop = 0; end
    if (drp) begin m_ovf = 1'b1; if (m_drop < 255) m_drop++; end
    if (p && empty) m_udf = 1'b1;
    if (pe) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0; pop = 1'b0; clr_flags = 1'b0;
    compare_model(tag);
  endtask

  typedef struct {
    logic          wr;
    logic [15:0]   d;
    logic          p;
    logic          c;
    logic [CW-1:0] cnt;
    logic          pnd;
    logic [15:0]   dp;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // wr, data, pop, clr -> count, pndng, D_pop, ovf, udf
    vecs[0] = '{1'b1, 16'h0A5C, 1'b0, 1'b0, 4'd1, 1'b1, 16'h0A5C, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h1111, 1'b1, 1'b0, 4'd1, 1'b1, 16'h1111, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h2222, 1'b0, 1'b1, 4'd2, 1'b1, 16'h1111, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h3333, 1'b1, 1'b0, 4'd2, 1'b1, 16'h2222, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b1, 16'h3333, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0};

    // Reset then idle.
    model_reset();
    #50 reset = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b0, 16'h0, 1'b0, 1'b0, "idle");
    check("idle.count", 32'(count), 32'h0);
    check("idle.D_pop", 32'(D_pop), 32'h0);

    // Vector table: latency, underflow, clear-vs-event, mid-range push+pop.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].wr, vecs[i].d, vecs[i].p, vecs[i].c, "vec");
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d.pndng", i), 32'(pndng), 32'(vecs[i].pnd));
      check($sformatf("vec%0d.D_pop", i), 32'(D_pop), 32'(vecs[i].dp));
      check($sformatf("vec%0d.ovf", i),   32'(ovf),   32'(vecs[i].ovf));
      check($sformatf("vec%0d.udf", i),   32'(udf),   32'(vecs[i].udf));
    end

    // Fill to full.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, "fill");
      check("fill.count", 32'(count), 32'(i + 1));
      check("fill.almost_full", 32'(almost_full), 32'(i + 1 >= 12));
    end
    check("fill.full", 32'(full), 32'h1);

    // Overflow with broadcast packets, then clear.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'hFFFF, 1'b0, 1'b0, "ovf");
    check("ovf.ovf", 32'(ovf), 32'h1);
    check("ovf.drop_cnt", 32'(drop_cnt), 32'h3);
    check("ovf.count", 32'(count), 32'hF);
    check("ovf.head", 32'(D_pop), 32'h0100);
    drive(1'b0, 16'h0, 1'b0, 1'b1, "clr");
    check("clr.ovf", 32'(ovf), 32'h0);
    check("clr.drop_cnt", 32'(drop_cnt), 32'h0);

    // Push and pop together while full.
    drive(1'b1, 16'h0200, 1'b1, 1'b0, "fullpp");
    check("fullpp.count", 32'(count), 32'hF);
    check("fullpp.drop_cnt", 32'(drop_cnt), 32'h0);
    check("fullpp.head", 32'(D_pop), 32'h0101);

    // Drain and confirm order, new packet last.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.order", 32'(D_pop), (i < DEPTH - 1) ? 32'(16'h0101 + 16'(i)) : 32'h0200);
      drive(1'b0, 16'h0, 1'b1, 1'b0, "drain");
    end

    // Pointer wrap with 20 more packets.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0, "wrap.w");
      check("wrap.head", 32'(D_pop), 32'(16'h0300 + 16'(i)));
      drive(1'b0, 16'h0, 1'b1, 1'b0, "wrap.p");
    end

    // Push and pop together while empty.
    drive(1'b1, 16'h0400, 1'b1, 1'b0, "emptypp");
    check("emptypp.count", 32'(count), 32'h1);
    check("emptypp.udf", 32'(udf), 32'h1);
    drive(1'b0, 16'h0, 1'b1, 1'b1, "emptypp.clr");

    // drop_cnt saturation.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 16'(i), 1'b0, 1'b0, "sat.fill");
    for (int i = 0; i < 260; i++) drive(1'b1, 16'hFFFF, 1'b0, 1'b0, "sat");
    check("sat.drop_cnt", 32'(drop_cnt), 32'hFF);
    drive(1'b0, 16'h0, 1'b0, 1'b1, "sat.clr");

    // Reset mid-stream at count 7, off the clock edge.
    for (int i = 0; i < 8; i++) drive(1'b0, 16'h0, 1'b1, 1'b0, "to7");
    check("to7.count", 32'(count), 32'h7);
    #3 reset = 1'b1;
    #1;
    check("rst.pndng", 32'(pndng), 32'h0);
    check("rst.count", 32'(count), 32'h0);
    model_reset();
    wr_en = 1'b1; wr_data = 16'hDEAD; pop = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_model("rst.hold");
    wr_en = 1'b0; pop = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    compare_model("rst.after");
    drive(1'b1, 16'h0201, 1'b0, 1'b0, "rst.wr");
    check("rst.head", 32'(D_pop), 32'h0201);

    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 3000; i++) begin
      int wr_pct;
      wr_pct = ((i / 150) % 2 == 0) ? 75 : 30;
      drive(1'($urandom_range(99) < wr_pct), 16'($urandom),
            1'($urandom_range(99) < (100 - wr_pct)), 1'($urandom_range(99) < 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_src_fifo.md
Name: bus_src_fifo

Overview:
Per-terminal source FIFO placed directly upstream of the bus generator/arbiter (bs_gnrtr_n_rbtr). One instance is used per driver port. The device side writes packets into it. The bus side sees a pending flag (pndng) and the head packet (D_pop), and removes the head with a one-cycle pop strobe. This block is the synthesizable counterpart of the testbench driver FIFO, and adds overflow and underflow accounting.

Parameters:
- pckg_sz, 16, packet width in bits. Bits [pckg_sz-1:pckg_sz-8] hold the destination ID; 8'hFF is broadcast.
- depth, 15, FIFO capacity in packets. Any value from 2 to 255; a power of two is not required.
- af_lvl, 12, count at or above which almost_full asserts. Must satisfy 1 <= af_lvl <= depth.

Ports:
- clk, in, 1: bus clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high; clears all state immediately.
- wr_en, in, 1: device-side write strobe; one packet per cycle when high.
- wr_data, in, pckg_sz: packet to enqueue.
- full, out, 1: count == depth.
- almost_full, out, 1: count >= af_lvl.
- count, out, $clog2(depth+1): number of stored packets.
- pndng, out, 1: count != 0; goes to the bus pndng input.
- D_pop, out, pckg_sz: head packet (first-word fall-through); goes to the bus D_pop input.
- pop, in, 1: bus-side dequeue strobe.
- ovf, out, 1: sticky flag; set when a write is dropped.
- udf, out, 1: sticky flag; set on a pop while empty.
- drop_cnt, out, 8: count of dropped writes; saturates at 255.
- clr_flags, in, 1: synchronous clear of ovf, udf and drop_cnt.

Behaviour:
- Reset state:
  - wr_ptr, rd_ptr and count = 0.
  - pndng, full, almost_full, ovf, udf = 0; drop_cnt = 0; D_pop = 0.
  - Memory contents are not cleared.
- Storage and pointers:
  - depth-entry register array.
  - Each pointer wraps explicitly from depth-1 to 0; no reliance on modulo-2^n arithmetic.
- D_pop:
  - Combinationally equals mem[rd_ptr] when pndng = 1.
  - Forced to 0 when empty.
- Write acceptance:
  - A write is accepted when wr_en && (!full || pop_eff).
  - Accepted data is stored at wr_ptr and wr_ptr advances.
  - Write latency: data written at edge N appears with pndng = 1 and on D_pop after edge N. There is no same-cycle bypass through an empty FIFO.
- Effective pop: pop_eff = pop && pndng.
  - rd_ptr advances on pop_eff.
  - The next head is visible on D_pop after the same edge.
- count update: count_next = count + (write accepted) - pop_eff.
- full, almost_full and pndng are combinational decodes of registered count. They settle after the edge that changes count.
- Simultaneous wr_en and pop_eff:
  - When full: both happen, count stays at depth, nothing is dropped.
  - When empty: pop_eff = 0, so the write is accepted and the pop is ignored. udf is set, count becomes 1.
  - In mid range: count is unchanged and both pointers advance.
- Overflow: wr_en while full && !pop_eff.
  - Data is discarded and memory is unchanged.
  - ovf <= 1; drop_cnt increments, saturating at 8'hFF.
- Underflow: pop while !pndng.
  - No state change except udf <= 1.
- clr_flags: clears ovf, udf and drop_cnt at the edge.
  - If a drop or underflow occurs in the same cycle, the new event wins: flag = 1, drop_cnt = 1.
- Reset mid-operation:
  - Asynchronous clear of all state; outputs take their reset values immediately.
  - In-flight packets are lost.
  - A write or pop asserted during reset is ignored.
- Content: no packet inspection or modification. Broadcast and unicast packets are stored identically.

Test Plan:
1. Reset then idle:
   - Release reset at 50 ns; hold wr_en = pop = 0 for 20 cycles.
   - Required: pndng = 0, count = 0, D_pop = 0, full = 0, ovf = udf = 0.
2. Single packet latency:
   - Write 16'h0A5C at edge N.
   - Required: after edge N, pndng = 1 and D_pop = 16'h0A5C.
   - Pop at edge N+1. Required: after edge N+1, pndng = 0 and D_pop = 0.
3. Fill, wrap and ordering:
   - Write 15 packets 16'h0100..16'h010E.
   - Required: full = 1, almost_full = 1 from count 12, count = 15.
   - Pop all 15. Required: output order matches input order.
   - Then write and pop 20 more packets to exercise pointer wrap. Required: order preserved.
4. Overflow:
   - With the FIFO full, write 16'hFFFF (broadcast) 3 times without pop.
   - Required: ovf = 1, drop_cnt = 3, count = 15, head unchanged (16'h0100).
   - Assert clr_flags. Required: ovf = 0, drop_cnt = 0.
5. Simultaneous push and pop:
   - When full: one push+pop cycle. Required: count stays 15, the new packet is at the tail, drop_cnt = 0.
   - When empty: one push+pop cycle. Required: count = 1, udf = 1.
6. Reset mid-stream:
   - Assert reset asynchronously (off-edge) while count = 7.
   - Required: pndng = 0 and count = 0 within the same cycle.
   - After release, a new write 16'h0201 is the head.
